sha_pad_stream: RTL

//  Parametrised SHA-2 message front-end: accepts a big-endian word stream, appends 0x80, zero

---
 rtl/sha_pad_stream.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sha_pad_stream.sv
// sha_pad_stream: SHA-2 message padder with valid/ready on both sides.
// Incoming big-endian words pass through to a single output register. The
// padder appends 0x80, a zero fill and the LEN_W-bit message bit length, and
// emits the result as 16-word blocks.
module sha_pad_stream #(
  parameter int W     = 32,
  parameter int LEN_W = 2 * W,
  parameter int NB_W  = $clog2(W / 8) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [NB_W-1:0] in_nbytes,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_first,
  output logic            out_last,
  output logic            out_msg_end
);

  localparam int NBYTES = W / 8;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD80,
    ZERO,
    LENHI,
    LENLO
  } state_t;

  state_t           state;
  state_t           pad_state;
  logic [3:0]       idx;
  logic [3:0]       idx_next;
  logic [LEN_W-1:0] bit_len;
  logic [LEN_W-1:0] len_base;
  logic [LEN_W-1:0] len_add;
  logic [NB_W-1:0]  bytes_acc;
  logic [W-1:0]     last_word;
  logic [W-1:0]     pad80_word;
  logic             adv;

  // The output register may load when it is empty or its word is being taken
  assign adv        = !out_valid || out_ready;
  assign in_ready   = rst && adv && (state == IDLE || state == DATA);
  assign idx_next   = idx + 4'd1;
  assign pad80_word = {8'h80, {(W - 8){1'b0}}};

  // The length field takes index 14 straight after padding if the next slot is 14
  assign pad_state = (idx_next == 4'd14) ? LENHI : ZERO;

  // The message length starts from zero on the first word of every message
  assign bytes_acc = in_last ? in_nbytes : NB_W'(NBYTES);
  assign len_add   = {{(LEN_W - NB_W){1'b0}}, bytes_acc} << 3;
  assign len_base  = (state == IDLE) ? '0 : bit_len;

  // Final word image: keep the first n bytes, put 0x80 at byte n, zero the rest
  always_comb begin
    last_word = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < int'(in_nbytes)) begin
        last_word[W-1-8*b -: 8] = in_data[W-1-8*b -: 8];
      end else if (b == int'(in_nbytes)) begin
        last_word[W-1-8*b -: 8] = 8'h80;
      end
    end
  end

  // Padding FSM and output register; everything advances only when adv is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= 4'd0;
      bit_len     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_msg_end <= 1'b0;
    end else if (adv) begin
      if ((state == IDLE || state == DATA) && !in_valid) begin
        out_valid <= 1'b0;
      end else begin
        out_valid   <= 1'b1;
        out_first   <= (idx == 4'd0);
        out_last    <= (idx == 4'd15);
        out_msg_end <= 1'b0;
        idx         <= idx_next;
        case (state)
          IDLE, DATA: begin
            bit_len <= len_base + len_add;
            if (!in_last) begin
              out_data <= in_data;
              state    <= DATA;
            end else if (in_nbytes == NB_W'(NBYTES)) begin
              out_data <= in_data;
              state    <= PAD80;
            end else begin
              out_data <= last_word;
              state    <= pad_state;
            end
          end
          PAD80: begin
            out_data <= pad80_word;
            state    <= pad_state;
          end
          ZERO: begin
            out_data <= '0;
            state    <= pad_state;
          end
          LENHI: begin
            out_data <= W'(bit_len >> W);
            state    <= LENLO;
          end
          LENLO: begin
            out_data    <= bit_len[W-1:0];
            out_msg_end <= 1'b1;
            state       <= IDLE;
          end
          default: begin
            out_data <= '0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
